// File: rtl/gc_stream_pkg.sv
// -----------------------------------------------------------------------------
// gc_stream_pkg
//   Shared types and constants for the garbler output stream serializer.
//   - rec_type_t     : 2-bit record type carried in the header word
//   - TAG_*          : garbler tag encodings seen on the input side
//   - HDR_*          : header word field positions
//   - gc_rec_t       : record layout {type, index, data} at the default
//                      geometry (S=16, K=128); the serializer uses the same
//                      packing order for any S/K via gc_rec_width().
// -----------------------------------------------------------------------------
package gc_stream_pkg;

    typedef enum logic [1:0] {
        REC_LABEL = 2'b00,
        REC_KEY   = 2'b01,
        REC_TABLE = 2'b10,
        REC_MASK  = 2'b11
    } rec_type_t;

    // Tag encodings. Any tag with bit 2 set is a label tag whose low bits
    // select which slots carry a label.
    localparam logic [2:0] TAG_IDLE  = 3'b000;
    localparam logic [2:0] TAG_KEY   = 3'b001;
    localparam logic [2:0] TAG_TABLE = 3'b010;
    localparam logic [2:0] TAG_MASK  = 3'b011;
    localparam int TAG_LABEL_BIT = 2;
    localparam int TAG_SLOT0_BIT = 0;
    localparam int TAG_SLOT1_BIT = 1;

    // Header word: type in the top HDR_TYPE_W bits, index from bit 0 up.
    localparam int HDR_TYPE_W  = 2;
    localparam int HDR_IDX_LSB = 0;

    localparam int GC_S_DEF = 16;
    localparam int GC_K_DEF = 128;

    typedef struct packed {
        rec_type_t             rtype;
        logic [GC_S_DEF-1:0]   index;
        logic [GC_K_DEF-1:0]   data;
    } gc_rec_t;

    function automatic int gc_rec_width(input int s, input int k);
        return HDR_TYPE_W + s + k;
    endfunction

endpackage

// File: rtl/gc_dual_push_fifo.sv
// -----------------------------------------------------------------------------
// gc_dual_push_fifo
//   Record FIFO accepting 0, 1 or 2 pushes and at most one pop per cycle.
//   The caller guarantees push_n <= free and pop only when !empty.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     push_n          number of records to push this cycle (0..2)
//     din0, din1      records; din0 is written first, din1 only if push_n==2
//     pop             retire the head entry
//     head            current head entry
//     head_next       entry behind the head (meaningful when 2+ entries held)
//     empty           no entries held
//     free            free entries, as seen before this cycle's push/pop
// -----------------------------------------------------------------------------
module gc_dual_push_fifo #(
    parameter int DEPTH = 16,
    parameter int REC_W = 146,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       push_n,
    input  logic [REC_W-1:0] din0,
    input  logic [REC_W-1:0] din1,
    input  logic             pop,
    output logic [REC_W-1:0] head,
    output logic [REC_W-1:0] head_next,
    output logic             empty,
    output logic [CW-1:0]    free
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Storage carries no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wr_ptr] <= din0;
        if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= din1;
    end

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(push_n) - CW'(pop);
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];
    assign empty     = (count == '0);
    assign free      = CW'(DEPTH) - count;

endmodule

// File: rtl/gc_stream_serializer.sv
// -----------------------------------------------------------------------------
// gc_stream_serializer
//   Captures the garbler core's tagged label/key/table/mask stream into a
//   dual-push FIFO and serialises each record as one header word followed by
//   K/W payload words (most-significant first) on a valid/ready link.
//   Optional build macro: GC_REC_COUNT_EN -- adds a saturating count of
//   emitted records, sent as a trailer word after the mask record; out_last
//   then marks the trailer and done follows its handshake.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     start               pulse: clear done/overflow/count, re-arm capture
//     tag                 garbler tag
//     index0/1, data0/1   slot 0/1 index and data
//     out_data/out_valid  serialised word and its valid
//     out_ready           downstream accept
//     out_last            final word of the stream
//     done                sticky, stream fully emitted
//     overflow            sticky, a cycle's records were dropped
// -----------------------------------------------------------------------------
module gc_stream_serializer
    import gc_stream_pkg::*;
#(
    parameter int S     = 16,
    parameter int K     = 128,
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   tag,
    input  logic [S-1:0] index0,
    input  logic [S-1:0] index1,
    input  logic [K-1:0] data0,
    input  logic [K-1:0] data1,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         done,
    output logic         overflow
);

    localparam int NW        = K / W;
    localparam int REC_W     = gc_rec_width(S, K);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int BW        = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NW - 1);

`ifdef GC_REC_COUNT_EN
    localparam bit MASK_LAST_ON_PAYLOAD = 1'b0;
    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAY, ST_DONE, ST_TRAILER} state_t;
`else
    localparam bit MASK_LAST_ON_PAYLOAD = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_DONE} state_t;
`endif

    // ------------------------------------------------------------------
    // Record helpers: layout is {type, index, data}.
    // ------------------------------------------------------------------
    function automatic logic [REC_W-1:0] pack_rec(input rec_type_t t,
                                                  input logic [S-1:0] idx,
                                                  input logic [K-1:0] d);
        return {t, idx, d};
    endfunction

    function automatic logic is_mask(input logic [REC_W-1:0] r);
        return r[REC_W-1 -: HDR_TYPE_W] == REC_MASK;
    endfunction

    function automatic logic [W-1:0] hdr_word(input logic [REC_W-1:0] r);
        logic [W-1:0] w;
        w = '0;
        w[W-1 -: HDR_TYPE_W] = r[REC_W-1 -: HDR_TYPE_W];
        w[HDR_IDX_LSB +: S]  = r[K +: S];
        return w;
    endfunction

    function automatic logic [W-1:0] pay_word(input logic [REC_W-1:0] r, input int b);
        return r[(NW-1-b)*W +: W];
    endfunction

    // ------------------------------------------------------------------
    // Tag decode
    // ------------------------------------------------------------------
    logic             armed;
    logic [1:0]       need;
    logic [REC_W-1:0] rec0, rec1;
    logic             mask_req;
    logic             fits;
    logic [1:0]       push_n;
    logic             drop;
    logic [CW-1:0]    fifo_free;

    always_comb begin
        need     = 2'd0;
        rec0     = '0;
        rec1     = '0;
        mask_req = 1'b0;
        if (armed) begin
            if (tag[TAG_LABEL_BIT]) begin
                // A lone slot-1 label still goes through the first push port.
                if (tag[TAG_SLOT0_BIT] && tag[TAG_SLOT1_BIT]) begin
                    need = 2'd2;
                    rec0 = pack_rec(REC_LABEL, index0, data0);
                    rec1 = pack_rec(REC_LABEL, index1, data1);
                end else if (tag[TAG_SLOT0_BIT]) begin
                    need = 2'd1;
                    rec0 = pack_rec(REC_LABEL, index0, data0);
                end else if (tag[TAG_SLOT1_BIT]) begin
                    need = 2'd1;
                    rec0 = pack_rec(REC_LABEL, index1, data1);
                end
            end else begin
                case (tag)
                    TAG_KEY: begin
                        need = 2'd2;
                        rec0 = pack_rec(REC_KEY, S'(0), data0);
                        rec1 = pack_rec(REC_KEY, S'(1), data1);
                    end
                    TAG_TABLE: begin
                        need = 2'd2;
                        rec0 = pack_rec(REC_TABLE, index0, data0);
                        rec1 = pack_rec(REC_TABLE, index1, data1);
                    end
                    TAG_MASK: begin
                        need     = 2'd1;
                        mask_req = 1'b1;
                        rec0     = pack_rec(REC_MASK, S'(0), data0);
                    end
                    TAG_IDLE: ;
                    default:  ;
                endcase
            end
        end
    end

    // All-or-nothing: the free count is the pre-pop value.
    assign fits   = (CW'(need) <= fifo_free);
    assign push_n = fits ? need : 2'd0;
    assign drop   = (need != 2'd0) && !fits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b1;
            overflow <= 1'b0;
        end else if (start) begin
            armed    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (drop)            overflow <= 1'b1;
            if (mask_req && fits) armed   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic             pop;
    logic [REC_W-1:0] head, head_next;
    logic             fifo_empty;
    logic             has_second;

    gc_dual_push_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_n    (push_n),
        .din0      (rec0),
        .din1      (rec1),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    // Lets the next header follow the last payload word without a bubble.
    assign has_second = (fifo_free <= CW'(DEPTH - 2));

`ifdef GC_REC_COUNT_EN
    logic [W-1:0] rec_cnt, rec_cnt_inc;

    assign rec_cnt_inc = (rec_cnt == '1) ? rec_cnt : rec_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rec_cnt <= '0;
        else if (start) rec_cnt <= '0;
        else if (pop)   rec_cnt <= rec_cnt_inc;
    end
`endif

    // ------------------------------------------------------------------
    // Serializer FSM; the output word registers are loaded alongside it.
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d, beat_nxt;
    logic [W-1:0]   od_d;
    logic           ov_d, ol_d;
    logic           hs;

    assign hs = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        beat_nxt = beat_q + 1'b1;
        od_d     = out_data;
        ov_d     = out_valid;
        ol_d     = out_last;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_HDR;
                    od_d    = hdr_word(head);
                    ov_d    = 1'b1;
                    ol_d    = 1'b0;
                end
            end
            ST_HDR: begin
                if (hs) begin
                    state_d = ST_PAY;
                    beat_d  = '0;
                    od_d    = pay_word(head, 0);
                    ol_d    = MASK_LAST_ON_PAYLOAD && is_mask(head) && (NW == 1);
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (beat_q == LAST_BEAT) begin
                        pop  = 1'b1;
                        ol_d = 1'b0;
                        if (is_mask(head)) begin
`ifdef GC_REC_COUNT_EN
                            state_d = ST_TRAILER;
                            od_d    = rec_cnt_inc;
                            ov_d    = 1'b1;
                            ol_d    = 1'b1;
`else
                            state_d = ST_DONE;
                            od_d    = '0;
                            ov_d    = 1'b0;
`endif
                        end else if (has_second) begin
                            state_d = ST_HDR;
                            od_d    = hdr_word(head_next);
                            ov_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            od_d    = '0;
                            ov_d    = 1'b0;
                        end
                    end else begin
                        beat_d = beat_nxt;
                        od_d   = pay_word(head, int'(beat_nxt));
                        ol_d   = MASK_LAST_ON_PAYLOAD && is_mask(head) && (beat_nxt == LAST_BEAT);
                    end
                end
            end
`ifdef GC_REC_COUNT_EN
            ST_TRAILER: begin
                if (hs) begin
                    state_d = ST_DONE;
                    od_d    = '0;
                    ov_d    = 1'b0;
                    ol_d    = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                ov_d = 1'b0;
                ol_d = 1'b0;
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            out_data  <= od_d;
            out_valid <= ov_d;
            out_last  <= ol_d;
        end
    end

    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_gc_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_gc_stream_serializer
//   Bench for gc_stream_serializer (S=16, K=128, W=32, DEPTH=16). A queue of
//   expected words, built from accepted records, is compared against every
//   handshake; flags and output stability are checked every cycle. Directed
//   scenarios pin the word sequences with literal values.
// -----------------------------------------------------------------------------
module tb_gc_stream_serializer;

`ifdef GC_REC_COUNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   tag;
    logic [15:0]  index0, index1;
    logic [127:0] data0, data1;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         done;
    logic         overflow;

    gc_stream_serializer #(.S(16), .K(128), .W(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tag       (tag),
        .index0    (index0),
        .index1    (index1),
        .data0     (data0),
        .data1     (data1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] w;
        bit          last;
        bit          rec_end;
        bit          done_after;
        bit          trailer;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cap_q[$];
    bit          capl_q[$];
    int          occ;
    bit          armed_m, ovf_m, done_m;
    int          cnt_m;
    bit          prev_stall;
    logic [31:0] prev_od;
    logic        prev_ol;

    function automatic void model_reset();
        exp_q.delete();
        occ        = 0;
        armed_m    = 1'b1;
        ovf_m      = 1'b0;
        done_m     = 1'b0;
        cnt_m      = 0;
        prev_stall = 1'b0;
    endfunction

    function automatic void add_rec(input int t, input logic [15:0] idx, input logic [127:0] d);
        exp_t e;
        e = '{w: (32'(t) << 30) | 32'(idx), last: 0, rec_end: 0, done_after: 0, trailer: 0};
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            e.w          = d[127 - 32*i -: 32];
            e.rec_end    = (i == 3);
            e.last       = (t == 3) && (i == 3) && !FEAT;
            e.done_after = e.last;
            e.trailer    = 0;
            exp_q.push_back(e);
        end
        if (FEAT && t == 3) begin
            e = '{w: 32'd0, last: 1, rec_end: 0, done_after: 1, trailer: 1};
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_valid", out_valid, 1'b0);
            model_reset();
        end else begin
            int   need;
            exp_t e;
            chk("overflow", overflow, ovf_m);
            chk("done", done, done_m);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_od);
                chk("hold_last", out_last, prev_ol);
            end
            if (out_valid) chk("valid_has_expected", exp_q.size() != 0, 1'b1);

            // Capture decision for the coming edge, using pre-pop occupancy.
            need = 0;
            if (armed_m) begin
                if (tag[2])            need = int'(tag[0]) + int'(tag[1]);
                else if (tag == 3'b011) need = 1;
                else if (tag != 3'b000) need = 2;
            end
            if (need > 0) begin
                if (need > DEPTH - occ) ovf_m = 1'b1;
                else begin
                    occ += need;
                    if (tag[2]) begin
                        if (tag[0]) add_rec(0, index0, data0);
                        if (tag[1]) add_rec(0, index1, data1);
                    end else if (tag == 3'b001) begin
                        add_rec(1, 16'd0, data0);
                        add_rec(1, 16'd1, data1);
                    end else if (tag == 3'b010) begin
                        add_rec(2, index0, data0);
                        add_rec(2, index1, data1);
                    end else begin
                        add_rec(3, 16'd0, data0);
                        armed_m = 1'b0;
                    end
                end
            end

            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word", out_data, e.trailer ? 32'(cnt_m) : e.w);
                chk("last", out_last, e.last);
                cap_q.push_back(out_data);
                capl_q.push_back(out_last);
                if (e.rec_end) begin
                    occ--;
                    cnt_m++;
                end
                if (e.done_after) done_m = 1'b1;
            end

            if (start) begin
                ovf_m   = 1'b0;
                armed_m = 1'b1;
                done_m  = 1'b0;
                cnt_m   = 0;
            end

            prev_stall = out_valid && !out_ready;
            prev_od    = out_data;
            prev_ol    = out_last;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [2:0] t, input logic [15:0] i0, input logic [15:0] i1,
                         input logic [127:0] d0, input logic [127:0] d1);
        @(posedge clk); #1;
        tag = t; index0 = i0; index1 = i1; data0 = d0; data1 = d1;
    endtask

    task automatic idle();
        drive(3'b000, 16'd0, 16'd0, 128'd0, 128'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drain(input string nm, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, (exp_q.size() == 0) && !out_valid, 1'b1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] dl, da, db;
        int           n, base;
        logic [2:0]   tsel [7];
        tsel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

        rst = 1'b0; start = 1'b0; tag = '0; index0 = '0; index1 = '0;
        data0 = '0; data1 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_last", out_last, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        rst = 1'b1;

        // Single label
        cap_q.delete(); capl_q.delete();
        dl = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        drive(3'b101, 16'd5, 16'd0, dl, 128'd0);
        idle();
        drain("single_drain", 50);
        chk("single_n", cap_q.size(), 5);
        chk("single_w0", cap_q[0], 32'h00000005);
        chk("single_w1", cap_q[1], 32'h00112233);
        chk("single_w2", cap_q[2], 32'h44556677);
        chk("single_w3", cap_q[3], 32'h8899AABB);
        chk("single_w4", cap_q[4], 32'hCCDDEEFF);
        chk("single_last", capl_q[4], 1'b0);

        // Dual label
        cap_q.delete(); capl_q.delete();
        da = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        db = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
        drive(3'b111, 16'd2, 16'd3, da, db);
        idle();
        drain("dual_drain", 50);
        chk("dual_n", cap_q.size(), 10);
        chk("dual_h0", cap_q[0], 32'h00000002);
        chk("dual_p0", cap_q[1], 32'h01020304);
        chk("dual_h1", cap_q[5], 32'h00000003);
        chk("dual_p1", cap_q[9], 32'hD1D2D3D4);

        // Keys then table
        cap_q.delete(); capl_q.delete();
        drive(3'b001, 16'h1234, 16'h5678, rnd128(), rnd128());
        drive(3'b010, 16'd0, 16'd1, rnd128(), rnd128());
        idle();
        drain("kt_drain", 100);
        chk("kt_n", cap_q.size(), 20);
        chk("kt_h0", cap_q[0], 32'h40000000);
        chk("kt_h1", cap_q[5], 32'h40000001);
        chk("kt_h2", cap_q[10], 32'h80000000);
        chk("kt_h3", cap_q[15], 32'h80000001);

        // Backpressure / overflow
        cap_q.delete(); capl_q.delete();
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("ovf_before_9th", overflow, 1'b0);
            drive(3'b010, 16'(i * 2), 16'(i * 2 + 1), rnd128(), rnd128());
        end
        idle();
        chk("ovf_after_9th", overflow, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("ovf_drain", 300);
        chk("ovf_words", cap_q.size(), 80);
        chk("ovf_last_hdr", cap_q[75], 32'h8000000F);
        pulse_start();
        chk("ovf_cleared", overflow, 1'b0);

        // Randomised traffic with random backpressure (no mask)
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            tag       = tsel[$urandom_range(0, 6)];
            index0    = 16'($urandom);
            index1    = 16'($urandom);
            data0     = rnd128();
            data1     = rnd128();
            out_ready = ($urandom_range(0, 3) != 0);
            start     = (exp_q.size() == 0) && !out_valid && ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        tag = '0; start = 1'b0; out_ready = 1'b1;
        drain("rand_drain", 3000);
        pulse_start();

        // Mask / termination
        cap_q.delete(); capl_q.delete();
        drive(3'b101, 16'd9, 16'd0, rnd128(), 128'd0);
        drive(3'b011, 16'd7, 16'd0, 128'hF000_0000_0000_0000_0000_0000_0000_0000, 128'd0);
        idle();
        drain("mask_drain", 100);
        chk("mask_n", cap_q.size(), FEAT ? 11 : 10);
        chk("mask_hdr", cap_q[5], 32'hC0000000);
        chk("mask_p0", cap_q[6], 32'hF0000000);
        chk("mask_p3", cap_q[9], 32'h00000000);
        chk("mask_p2_last", capl_q[8], 1'b0);
        if (FEAT) begin
            chk("mask_p3_last", capl_q[9], 1'b0);
            chk("trailer_w", cap_q[10], 32'h00000002);
            chk("trailer_last", capl_q[10], 1'b1);
        end else begin
            chk("mask_p3_last", capl_q[9], 1'b1);
        end
        chk("mask_done", done, 1'b1);
        base = cap_q.size();
        drive(3'b101, 16'd1, 16'd0, rnd128(), 128'd0);
        idle();
        repeat (10) @(posedge clk);
        #1;
        chk("disarm_no_words", cap_q.size(), base);
        chk("disarm_valid", out_valid, 1'b0);
        chk("disarm_overflow", overflow, 1'b0);
        chk("disarm_done", done, 1'b1);
        pulse_start();
        chk("start_clears_done", done, 1'b0);

        // Reset mid-payload
        cap_q.delete(); capl_q.delete();
        drive(3'b101, 16'd4, 16'd0, rnd128(), 128'd0);
        idle();
        n = 0;
        while (cap_q.size() < 3 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_mid_reached", cap_q.size(), 3);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_data, 32'h0);
        chk("rst_mid_last", out_last, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cap_q.delete(); capl_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_words", cap_q.size(), 0);
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_overflow", overflow, 1'b0);
        drive(3'b110, 16'd0, 16'h00AB, 128'd0, rnd128());
        idle();
        drain("recover_drain", 50);
        chk("recover_n", cap_q.size(), 5);
        chk("recover_hdr", cap_q[0], 32'h000000AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gc_stream_serializer.md
Name: gc_stream_serializer

Overview:
- Sits directly downstream of the garbler core. Consumes its tagged label/key/table/mask output stream.
- Buffers records in a small dual-push FIFO and serialises each record into W-bit words on a valid/ready link toward host/evaluator transport.
- Replaces bench-side capture with synthesizable streaming.

Parameters:
- S, 16: index width; S <= W-2.
- K, 128: label/data width; K % W == 0.
- W, 32: output word width.
- DEPTH, 16: FIFO records; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; clears done/overflow/counters and re-arms capture.
- tag  in  3  garbler tag.
- index0  in  S  slot-0 index.
- index1  in  S  slot-1 index.
- data0  in  K  slot-0 data.
- data1  in  K  slot-1 data.
- out_data  out  W  serialised word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final word of stream.
- done  out  1  sticky; mask record fully emitted.
- overflow  out  1  sticky; records dropped.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, out_last=0, done=0, overflow=0; FIFO empty; FSM IDLE; capture armed.
- Tag decode, sampled every posedge while armed:
  - tag[2]=1: label records. Slot0 pushed if tag[0]; slot1 pushed if tag[1]. Type 00, index from indexN.
  - 3'b001: two key records, type 01, index 0 then 1.
  - 3'b010: two table records, type 10, index0/index1.
  - 3'b011: one mask record, type 11, index 0, data0. Capture disarms after this push.
  - 3'b000: idle.
- Push order within a cycle: slot0 before slot1.
- If free entries < records needed that cycle, drop all of that cycle's records and set overflow. A partial push never occurs.
- Simultaneous push and pop in one cycle are both honoured; free count is evaluated before that cycle's pop.
- Record word format:
  - Header: bits[W-1:W-2]=type, bits[S-1:0]=index, remaining bits 0.
  - Then K/W payload words, most-significant first.
- FSM:
  - IDLE -> HDR when FIFO non-empty.
  - HDR -> PAY on header handshake.
  - PAY counts K/W words. After the last handshake: pop the entry, then go to HDR if FIFO non-empty, else IDLE. If the popped record was the mask, go to DONE instead.
  - DONE holds out_valid=0 and done=1 until start or reset.
- Outputs are registered. A record pushed at edge t gives a header with out_valid=1 at edge t+1 at the earliest.
- out_data/out_valid/out_last hold stable while out_valid && !out_ready.
- Throughput: one word per cycle when out_ready is held high.
- out_last=1 only on the mask record's final payload word.
- start while mid-record:
  - The current record finishes.
  - FIFO contents are kept.
  - done/overflow clear; capture re-arms.
- Tags after disarm are ignored; overflow is unaffected.

Optional Feature:
- Macro: GC_REC_COUNT_EN.
- Defined:
  - A W-bit counter of records emitted, saturating, cleared by reset/start.
  - After the mask record, FSM enters TRAILER and emits one word equal to the count including the mask record.
  - out_last moves to the trailer word; done sets after the trailer handshake.
- Undefined: no counter, no TRAILER state, behaviour as above.

Decomposition:
- Package gc_stream_pkg holds:
  - rec_type_t enum {REC_LABEL, REC_KEY, REC_TABLE, REC_MASK}.
  - Tag encoding constants.
  - Header field positions.
  - Packed record struct {type, index, data}.
- Sub-module gc_dual_push_fifo: parameterised DEPTH, 0/1/2 pushes plus one pop per cycle, reports free count.
- Decoder and serializer FSM stay in the top module.

Test Plan:
- Single label (S=16, K=128, W=32): tag=3'b101, index0=5, data0=128'h00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 → words 0x00000005, 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; out_last=0.
- Dual label: tag=3'b111, index0=2, index1=3 → 10 words; header 0x00000002 precedes 0x00000003; payload order matches slots.
- Keys then table: tag=3'b001, then tag=3'b010 with index0=0, index1=1 → headers 0x40000000, 0x40000001, 0x80000000, 0x80000001 in order.
- Backpressure/overflow: out_ready=0, nine consecutive tag=3'b010 cycles → first 8 stored (16 records); 9th dropped and overflow=1 the following cycle; after release, exactly 16 records (80 words) emitted.
- Mask/termination: tag=3'b011, data0=128'hF0…0 → header 0xC0000000, 4 payload words, out_last on 4th payload word, done=1 next cycle; a subsequent tag=3'b101 produces no output. With GC_REC_COUNT_EN after one label + mask, trailer=0x00000002 carries out_last.
- Reset mid-payload: rst=0 during 2nd payload word → out_valid=0 immediately; after release FIFO empty, no residual words, flags 0.
